operand_fetch_stage: RTL
========================

// Module: operand_fetch_stage
// PURPOSE
//   Decode/operand-fetch pipeline stage directly upstream of the execute stage and the
//   Regfile read ports. Accepts fetched instructions and drives regno1/regno2 into the
//   Regfile. Checks a per-register pending-write scoreboard for RAW/WAW hazards and
//   bypasses same-cycle writeback data. Issues decoded operands into an ID/EX output
//   register with a valid/ready handshake.
// PARAMETERS
//   WORD_SIZE    32   data/PC width; matches Regfile WORD_SIZE
//   INDEX_WIDTH  4    register index width; matches Regfile INDEX_WIDTH
//   INST_WIDTH   32   instruction width; must be >= 4 + 3*INDEX_WIDTH + 16
// PORTS
//   clk        in   1            clock, all state updates on posedge
//   reset      in   1            asynchronous, active-low reset
//   inValid    in   1            upstream instruction valid
//   inReady    out  1            stage accepts instruction this cycle
//   inInst     in   INST_WIDTH   instruction word
//   inPC       in   WORD_SIZE    instruction PC
//   regno1     out  INDEX_WIDTH  Regfile read index 1 (= rs1 of inInst, combinational)
//   regno2     out  INDEX_WIDTH  Regfile read index 2 (= rs2 of inInst, combinational)
//   dataOut1   in   WORD_SIZE    Regfile read data 1 (combinational read)
//   dataOut2   in   WORD_SIZE    Regfile read data 2
//   wbEn       in   1            writeback enable (same signal driving Regfile wrtEn)
//   wbRegno    in   INDEX_WIDTH  writeback register index
//   wbData     in   WORD_SIZE    writeback data
//   flush      in   1            kill output register and clear scoreboard
//   outValid   out  1            ID/EX register holds a valid instruction
//   outReady   in   1            execute stage consumes outputs this cycle
//   outOp      out  4            opcode
//   outRd      out  INDEX_WIDTH  destination register
//   outWrites  out  1            instruction writes outRd (= ~op[3])
//   outA/outB  out  WORD_SIZE    operand values for rs1/rs2
//   outImm     out  WORD_SIZE    sign-extended 16-bit immediate
//   outPC      out  WORD_SIZE    registered inPC
//   stallCount out  16           saturating count of stalled cycles
// BEHAVIOUR
//   Fields (MSB down): op[4] | rd | rs1 | rs2 | ... | imm[15:0] (inInst[15:0]).
//   Reset: outValid=0, all other out* regs=0, pending[]=0, stallCount=0.
//   Hazard (combinational) when any of the following holds:
//     - pending[rs1] and not (wbEn && wbRegno==rs1)
//     - pending[rs2] and not (wbEn && wbRegno==rs2)
//     - op[3]==0 and pending[rd] and not (wbEn && wbRegno==rd)   (WAW)
//     Both sources are always checked, even if the opcode ignores rs2.
//   inReady = !flush && !hazard && (!outValid || outReady).
//   Issue = inValid && inReady. On issue at posedge: load all out* regs, outValid<=1.
//   Operand bypass: outA = (wbEn && wbRegno==rs1) ? wbData : dataOut1; same for outB.
//     The Regfile write is not visible on its read port until the next cycle.
//   No issue && outReady && outValid -> outValid<=0. Stalled -> out* regs hold.
//   Scoreboard per posedge:
//     - wbEn clears pending[wbRegno].
//     - Issue with outWrites sets pending[rd]; set wins over a same-cycle clear of
//       the same index.
//   flush (synchronous): outValid<=0, all pending<=0, no issue; overrides everything.
//     wbEn in the flush cycle has no effect on the scoreboard.
//   stallCount increments when inValid && !inReady && !flush; saturates at 16'hFFFF.
//   Latency: one cycle from accept to outValid. Throughput 1/cycle with no hazards.
//   Reset asserted mid-operation returns all state to reset values immediately.
// TESTING
//   Reset then back-to-back independent ops (r1<-.., r2<-..) -> both issue on
//     consecutive cycles, pending[1]=pending[2]=1.
//   Issue ADD rd=3; next op reads r3 with no wb -> inReady=0, stallCount counts up;
//     wbEn=1 wbRegno=3 wbData=8675309 -> issue same cycle, outA=8675309.
//   Instruction reads r5 while wbEn writes r5=42 and Regfile still reads 0 ->
//     outA=42 (bypass).
//   outReady=0 with outValid=1 -> inReady=0, out* hold; outReady=1 -> next issues.
//   Issue rd=7, then flush -> outValid=0, pending[7]=0; an op reading r7 issues next cycle.
//   Issue writing rd=4 in the same cycle wbEn clears r4 -> pending[4]=1 afterwards.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage_if
// Description : Bundle of the instruction-in, Regfile, writeback, and ID/EX
//               signals of the operand fetch stage. The master modport is
//               the surrounding pipeline; the slave modport is the stage.
// Revision    : 1.0  initial release
// ============================================================================
interface operand_fetch_stage_if #(
    parameter int WORD_SIZE   = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int INST_WIDTH  = 32
);
    // Upstream instruction handshake
    logic                   inValid;
    logic                   inReady;
    logic [INST_WIDTH-1:0]  inInst;
    logic [WORD_SIZE-1:0]   inPC;

    // Regfile read ports
    logic [INDEX_WIDTH-1:0] regno1;
    logic [INDEX_WIDTH-1:0] regno2;
    logic [WORD_SIZE-1:0]   dataOut1;
    logic [WORD_SIZE-1:0]   dataOut2;

    // Writeback snoop
    logic                   wbEn;
    logic [INDEX_WIDTH-1:0] wbRegno;
    logic [WORD_SIZE-1:0]   wbData;

    // Pipeline control
    logic                   flush;

    // ID/EX register
    logic                   outValid;
    logic                   outReady;
    logic [3:0]             outOp;
    logic [INDEX_WIDTH-1:0] outRd;
    logic                   outWrites;
    logic [WORD_SIZE-1:0]   outA;
    logic [WORD_SIZE-1:0]   outB;
    logic [WORD_SIZE-1:0]   outImm;
    logic [WORD_SIZE-1:0]   outPC;
    logic [15:0]            stallCount;

    modport master (
        output inValid, inInst, inPC, dataOut1, dataOut2,
               wbEn, wbRegno, wbData, flush, outReady,
        input  inReady, regno1, regno2, outValid, outOp, outRd, outWrites,
               outA, outB, outImm, outPC, stallCount
    );

    modport slave (
        input  inValid, inInst, inPC, dataOut1, dataOut2,
               wbEn, wbRegno, wbData, flush, outReady,
        output inReady, regno1, regno2, outValid, outOp, outRd, outWrites,
               outA, outB, outImm, outPC, stallCount
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Decode / operand fetch stage. Drives the Regfile read
//               indices, tracks pending register writes in a scoreboard to
//               stall on RAW/WAW hazards, bypasses same-cycle writeback data
//               and issues into a valid/ready ID/EX output register.
// Revision    : 1.0  initial release
// ============================================================================
module operand_fetch_stage #(
    parameter int WORD_SIZE   = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int INST_WIDTH  = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,     // asynchronous, active low
    operand_fetch_stage_if.slave  bus
);
    // Field positions, MSB down: op[4] | rd | rs1 | rs2 | spare | imm[15:0]
    localparam int c_NUM_REGS = 1 << INDEX_WIDTH;
    localparam int c_OP_LSB   = INST_WIDTH - 4;
    localparam int c_RD_LSB   = c_OP_LSB - INDEX_WIDTH;
    localparam int c_RS1_LSB  = c_RD_LSB - INDEX_WIDTH;
    localparam int c_RS2_LSB  = c_RS1_LSB - INDEX_WIDTH;
    localparam int c_SPARE    = c_RS2_LSB - 16;

    // Decoded fields
    logic [3:0]             w_op;
    logic [INDEX_WIDTH-1:0] w_rd;
    logic [INDEX_WIDTH-1:0] w_rs1;
    logic [INDEX_WIDTH-1:0] w_rs2;
    logic [WORD_SIZE-1:0]   w_imm;
    logic                   w_writes;

    // Hazard / handshake
    logic                   w_wbHitRs1;
    logic                   w_wbHitRs2;
    logic                   w_wbHitRd;
    logic                   w_hazard;
    logic                   w_inReady;
    logic                   w_issue;
    logic [WORD_SIZE-1:0]   w_opA;
    logic [WORD_SIZE-1:0]   w_opB;
    logic [c_NUM_REGS-1:0]  w_pendingNext;

    // State
    logic [c_NUM_REGS-1:0]  r_pending;
    logic                   r_outValid;
    logic [3:0]             r_outOp;
    logic [INDEX_WIDTH-1:0] r_outRd;
    logic                   r_outWrites;
    logic [WORD_SIZE-1:0]   r_outA;
    logic [WORD_SIZE-1:0]   r_outB;
    logic [WORD_SIZE-1:0]   r_outImm;
    logic [WORD_SIZE-1:0]   r_outPC;
    logic [15:0]            r_stallCount;

    assign w_op     = bus.inInst[c_OP_LSB  +: 4];
    assign w_rd     = bus.inInst[c_RD_LSB  +: INDEX_WIDTH];
    assign w_rs1    = bus.inInst[c_RS1_LSB +: INDEX_WIDTH];
    assign w_rs2    = bus.inInst[c_RS2_LSB +: INDEX_WIDTH];
    assign w_imm    = {{(WORD_SIZE-16){bus.inInst[15]}}, bus.inInst[15:0]};
    assign w_writes = ~w_op[3];

    // Bits between rs2 and the immediate carry no meaning for this stage.
    generate
        if (c_SPARE > 0) begin : g_spare
            logic w_unusedSpare;
            assign w_unusedSpare = ^bus.inInst[c_RS2_LSB-1:16];
        end
    endgenerate

    // A writeback landing this cycle resolves the pending write it matches.
    assign w_wbHitRs1 = bus.wbEn && (bus.wbRegno == w_rs1);
    assign w_wbHitRs2 = bus.wbEn && (bus.wbRegno == w_rs2);
    assign w_wbHitRd  = bus.wbEn && (bus.wbRegno == w_rd);

    // rs2 is checked unconditionally; the decoder does not know which ops use it.
    assign w_hazard = (r_pending[w_rs1] && !w_wbHitRs1)
                   || (r_pending[w_rs2] && !w_wbHitRs2)
                   || (w_writes && r_pending[w_rd] && !w_wbHitRd);

    assign w_inReady = !bus.flush && !w_hazard && (!r_outValid || bus.outReady);
    assign w_issue   = bus.inValid && w_inReady;

    // The Regfile shows a write only from the next cycle, so forward it here.
    assign w_opA = w_wbHitRs1 ? bus.wbData : bus.dataOut1;
    assign w_opB = w_wbHitRs2 ? bus.wbData : bus.dataOut2;

    // Scoreboard next state: flush clears all, else a new pending write beats a same-index clear.
    always_comb begin
        w_pendingNext = r_pending;
        if (bus.flush) begin
            w_pendingNext = '0;
        end else begin
            if (bus.wbEn) begin
                w_pendingNext[bus.wbRegno] = 1'b0;
            end
            if (w_issue && w_writes) begin
                w_pendingNext[w_rd] = 1'b1;
            end
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pendingNext;
        end
    end

    // ID/EX register: load on issue, drain when consumed, hold while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outValid  <= 1'b0;
            r_outOp     <= '0;
            r_outRd     <= '0;
            r_outWrites <= 1'b0;
            r_outA      <= '0;
            r_outB      <= '0;
            r_outImm    <= '0;
            r_outPC     <= '0;
        end else if (bus.flush) begin
            r_outValid  <= 1'b0;
        end else if (w_issue) begin
            r_outValid  <= 1'b1;
            r_outOp     <= w_op;
            r_outRd     <= w_rd;
            r_outWrites <= w_writes;
            r_outA      <= w_opA;
            r_outB      <= w_opB;
            r_outImm    <= w_imm;
            r_outPC     <= bus.inPC;
        end else if (bus.outReady) begin
            r_outValid  <= 1'b0;
        end
    end

    // Saturating count of cycles an offered instruction was held back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCount <= '0;
        end else if (bus.inValid && !w_inReady && !bus.flush
                     && (r_stallCount != 16'hFFFF)) begin
            r_stallCount <= r_stallCount + 16'd1;
        end
    end

    assign bus.inReady    = w_inReady;
    assign bus.regno1     = w_rs1;
    assign bus.regno2     = w_rs2;
    assign bus.outValid   = r_outValid;
    assign bus.outOp      = r_outOp;
    assign bus.outRd      = r_outRd;
    assign bus.outWrites  = r_outWrites;
    assign bus.outA       = r_outA;
    assign bus.outB       = r_outB;
    assign bus.outImm     = r_outImm;
    assign bus.outPC      = r_outPC;
    assign bus.stallCount = r_stallCount;
endmodule
`default_nettype wire
